hwpe_ctrl_periph2reqrsp: RTL and testbench
==========================================

# hwpe_ctrl_periph2reqrsp

Protocol bridge that accepts transactions as a slave on the HWPE peripheral (req/gnt/r_valid) bus and re-issues them as an initiator on the reqrsp (q/p valid-ready) bus. It sits between a cluster peripheral interconnect port and a reqrsp-based target such as a register file or memory adapter. It tracks up to `MAX_OUTSTANDING` in-flight transactions. Responses return in order, and the originating peripheral ID is restored on each response.

## Interface
- `AW`, 32, address width (both sides)
- `DW`, 32, data width; strobe/byte-enable width is `DW/8`
- `ID_WIDTH`, 8, peripheral transaction ID width
- `MAX_OUTSTANDING`, 4, maximum in-flight transactions; power of two, ≥2

Ports:
- `clk_i`  in  1  clock
- `rst_i`  in  1  reset, synchronous, active-high
- `periph_req_i`  in  1  peripheral request
- `periph_gnt_o`  out  1  peripheral grant
- `periph_add_i`  in  AW  address
- `periph_wen_i`  in  1  1 = read, 0 = write
- `periph_be_i`  in  DW/8  byte enables
- `periph_data_i`  in  DW  write data
- `periph_id_i`  in  ID_WIDTH  transaction ID
- `periph_r_data_o`  out  DW  response data
- `periph_r_valid_o`  out  1  response valid, single-cycle pulse, no backpressure
- `periph_r_id_o`  out  ID_WIDTH  response ID
- `q_addr_o`, `q_write_o`, `q_strb_o`, `q_data_o`  out  AW/1/DW/8/DW  request channel
- `q_valid_o`  out  1 / `q_ready_i`  in  1  request handshake
- `p_data_i`  in  DW  response data
- `p_valid_i`  in  1 / `p_ready_o`  out  1  response handshake

## Operation
- **Request register.** There is one entry, holding `q_*` and a `full` flag.
  - `periph_gnt_o = periph_req_i && (!full || q_ready_i) && (cnt < MAX_OUTSTANDING)`. It is combinational on these inputs.
  - On grant, the register loads on the next edge:
    - `q_addr = add`
    - `q_write = !wen`
    - `q_strb = wen ? '1 : be`
    - `q_data = data`
    - `full` is set to 1.
  - On a q handshake without a new grant, `full` is set to 0.
  - `q_valid_o = full`. The `q_*` outputs stay stable while `q_valid_o && !q_ready_i`.
- **ID FIFO.** Depth is `MAX_OUTSTANDING`, in order.
  - It pushes `periph_id_i` on grant.
  - It pops on the p handshake (`p_valid_i && p_ready_o`).
- **Outstanding counter.** `cnt` has width `$clog2(MAX_OUTSTANDING+1)`.
  - It increments on grant and decrements on pop.
  - A simultaneous grant and pop leaves it unchanged.
  - A pop in the same cycle does not enable a grant when `cnt == MAX_OUTSTANDING`. The grant is deferred one cycle.
- **Response path.**
  - `p_ready_o = 1` whenever not in reset.
  - Each p handshake produces one `periph_r_valid_o` pulse, with `r_data = p_data_i` and `r_id` = FIFO head.
  - Every q transaction, read or write, receives exactly one p response.
- **Stray response.** A p response with `cnt == 0` is consumed, produces no `r_valid`, and leaves `cnt` at 0.
- **ID FIFO pointers** wrap modulo `MAX_OUTSTANDING`.

## Timing
- **Reset values.** All of the following are 0:
  - `periph_gnt_o`, `periph_r_valid_o`, `periph_r_data_o`, `periph_r_id_o`
  - `q_valid_o`, `q_addr_o`, `q_write_o`, `q_strb_o`, `q_data_o`
  - `p_ready_o`
  - `cnt` and the FIFO pointers.
- **Request latency.** A grant in cycle N gives `q_valid_o` in cycle N+1.
- **Back-to-back requests.** With `q_ready_i` held high, one request is granted per cycle.
- **Response latency.** A p handshake in cycle M gives `periph_r_valid_o` in cycle M+1 (macro defined) or M (macro undefined).
- **Reset mid-operation.** The request register, FIFO and counter are cleared, and in-flight transactions are dropped. Late p responses after reset follow the stray-response rule.

## Configuration
- `HWPE_CTRL_PERIPH2REQRSP_RSP_REG_EN`
  - **Defined:** `periph_r_valid_o`, `periph_r_data_o` and `periph_r_id_o` are registered, giving +1 cycle of response latency. `r_data` and `r_id` hold their last values when `r_valid` is 0.
  - **Undefined:** the response outputs are combinational from `p_valid_i`/`p_data_i`/FIFO head. `r_data` and `r_id` are don't-care when `r_valid` is 0.

## Test plan
- **Single read (macro defined).** Stimulus: `add=0x100`, `wen=1`, `id=3`; target responds with `p_data=0xDEADBEEF` 2 cycles after the q handshake. Required: gnt in cycle 0; `q_valid`, `q_write=0`, `q_strb=0xF` in cycle 1; `r_valid`, `r_data=0xDEADBEEF`, `r_id=3` one cycle after `p_valid`.
- **Write.** Stimulus: `wen=0`, `be=0x3`, `data=0x12345678`, `id=7`. Required: `q_write=1`, `q_strb=0x3`, `q_data=0x12345678`; exactly one `r_valid` with `r_id=7`.
- **Request backpressure.** Stimulus: `q_ready_i=0` for 5 cycles with 2 requests pending. Required: `q_*` stable; second gnt low until `q_ready_i` rises; second request appears the cycle after.
- **Outstanding limit.** Stimulus: `MAX_OUTSTANDING=4`; 5 reads with IDs 1..5 and no p responses. Required: only 4 grants. Then first p arrives: 5th grant one cycle later. Responses return with IDs 1,2,3,4,5 in order, and the FIFO wraps.
- **Simultaneous grant and pop.** Stimulus: grant and p handshake in the same cycle at `cnt=2`. Required: `cnt` stays 2; correct ID paired.
- **Reset mid-flight.** Stimulus: `rst_i` asserted with 3 outstanding, then 3 late p responses. Required: all outputs 0 during reset; late responses produce no `r_valid`; `cnt` remains 0.

Source files
------------

// File: rtl/hwpe_ctrl_periph2reqrsp.sv
// hwpe_ctrl_periph2reqrsp
// Bridges a HWPE peripheral slave port (req/gnt/r_valid) onto a reqrsp
// initiator port (q/p valid-ready). A single request register feeds the
// q channel, an in-order ID FIFO restores the peripheral ID on responses,
// and an outstanding counter caps the number of in-flight transactions.
//
// Optional feature macro: HWPE_CTRL_PERIPH2REQRSP_RSP_REG_EN
//   defined   -> response outputs registered (+1 cycle latency, hold value)
//   undefined -> response outputs combinational from the p channel

module hwpe_ctrl_periph2reqrsp #(
  parameter int unsigned AW              = 32,
  parameter int unsigned DW              = 32,
  parameter int unsigned ID_WIDTH        = 8,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  // peripheral slave side
  input  logic                periph_req_i,
  output logic                periph_gnt_o,
  input  logic [AW-1:0]       periph_add_i,
  input  logic                periph_wen_i,
  input  logic [DW/8-1:0]     periph_be_i,
  input  logic [DW-1:0]       periph_data_i,
  input  logic [ID_WIDTH-1:0] periph_id_i,
  output logic [DW-1:0]       periph_r_data_o,
  output logic                periph_r_valid_o,
  output logic [ID_WIDTH-1:0] periph_r_id_o,
  // reqrsp request channel
  output logic [AW-1:0]       q_addr_o,
  output logic                q_write_o,
  output logic [DW/8-1:0]     q_strb_o,
  output logic [DW-1:0]       q_data_o,
  output logic                q_valid_o,
  input  logic                q_ready_i,
  // reqrsp response channel
  input  logic [DW-1:0]       p_data_i,
  input  logic                p_valid_i,
  output logic                p_ready_o
);

  localparam int unsigned BW    = DW / 8;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);

  // request register
  logic                r_full;
  logic [AW-1:0]       r_q_addr;
  logic                r_q_write;
  logic [BW-1:0]       r_q_strb;
  logic [DW-1:0]       r_q_data;

  // ID FIFO and outstanding counter
  logic [ID_WIDTH-1:0] r_id_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_gnt;
  logic                w_q_hs;
  logic                w_p_ready;
  logic                w_pop;
  logic [ID_WIDTH-1:0] w_head_id;

  // The limit check uses the registered count only, so a pop in the same
  // cycle never frees a slot early: the grant is deferred by one cycle.
  assign w_gnt = !rst_i && periph_req_i && (!r_full || q_ready_i) &&
                 (r_cnt < CNT_W'(MAX_OUTSTANDING));
  assign w_q_hs    = r_full && q_ready_i;
  assign w_p_ready = !rst_i;
  // Responses arriving with nothing outstanding are swallowed silently.
  assign w_pop     = p_valid_i && w_p_ready && (r_cnt != '0);
  assign w_head_id = r_id_mem[r_rd_ptr];

  assign periph_gnt_o = w_gnt;
  assign p_ready_o    = w_p_ready;
  assign q_valid_o    = r_full;
  assign q_addr_o     = r_q_addr;
  assign q_write_o    = r_q_write;
  assign q_strb_o     = r_q_strb;
  assign q_data_o     = r_q_data;

  // Request register: load on grant, drain on q handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_full    <= 1'b0;
      r_q_addr  <= '0;
      r_q_write <= 1'b0;
      r_q_strb  <= '0;
      r_q_data  <= '0;
    end else if (w_gnt) begin
      r_full    <= 1'b1;
      r_q_addr  <= periph_add_i;
      r_q_write <= !periph_wen_i;
      r_q_strb  <= periph_wen_i ? {BW{1'b1}} : periph_be_i;
      r_q_data  <= periph_data_i;
    end else if (w_q_hs) begin
      r_full    <= 1'b0;
    end
  end

  // ID storage: written at the tail on every grant; no reset needed since
  // an entry is only read while the counter says it is valid.
  always_ff @(posedge clk_i) begin
    if (w_gnt) begin
      r_id_mem[r_wr_ptr] <= periph_id_i;
    end
  end

  // FIFO pointers (wrap naturally, depth is a power of two) and counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_gnt) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_gnt && !w_pop) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else if (!w_gnt && w_pop) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

`ifdef HWPE_CTRL_PERIPH2REQRSP_RSP_REG_EN
  logic                r_rsp_valid;
  logic [DW-1:0]       r_rsp_data;
  logic [ID_WIDTH-1:0] r_rsp_id;

  // Registered response: one-cycle pulse, data and ID hold between pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
    end else begin
      r_rsp_valid <= w_pop;
      if (w_pop) begin
        r_rsp_data <= p_data_i;
        r_rsp_id   <= w_head_id;
      end
    end
  end

  assign periph_r_valid_o = r_rsp_valid;
  assign periph_r_data_o  = r_rsp_data;
  assign periph_r_id_o    = r_rsp_id;
`else
  // Combinational response; data/ID are forced to zero outside a pulse.
  assign periph_r_valid_o = w_pop;
  assign periph_r_data_o  = w_pop ? p_data_i  : '0;
  assign periph_r_id_o    = w_pop ? w_head_id : '0;
`endif

endmodule

// File: tb/tb_hwpe_ctrl_periph2reqrsp.sv
// Directed bench for hwpe_ctrl_periph2reqrsp (default parameters).
// Inputs change at posedge+1, outputs are sampled at posedge+3.
// Works with HWPE_CTRL_PERIPH2REQRSP_RSP_REG_EN defined or undefined.

module tb_hwpe_ctrl_periph2reqrsp;

  logic        clk = 1'b0;
  logic        rst;
  logic        periph_req;
  logic        periph_gnt;
  logic [31:0] periph_add;
  logic        periph_wen;
  logic [3:0]  periph_be;
  logic [31:0] periph_data;
  logic [7:0]  periph_id;
  logic [31:0] r_data;
  logic        r_valid;
  logic [7:0]  r_id;
  logic [31:0] q_addr;
  logic        q_write;
  logic [3:0]  q_strb;
  logic [31:0] q_data;
  logic        q_valid;
  logic        q_ready;
  logic [31:0] p_data;
  logic        p_valid;
  logic        p_ready;

  int n_checks = 0;
  int n_pass   = 0;
  int vcyc;    // cycle offset of r_valid relative to the p handshake

  always #5 clk = ~clk;

  hwpe_ctrl_periph2reqrsp dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .periph_req_i     (periph_req),
    .periph_gnt_o     (periph_gnt),
    .periph_add_i     (periph_add),
    .periph_wen_i     (periph_wen),
    .periph_be_i      (periph_be),
    .periph_data_i    (periph_data),
    .periph_id_i      (periph_id),
    .periph_r_data_o  (r_data),
    .periph_r_valid_o (r_valid),
    .periph_r_id_o    (r_id),
    .q_addr_o         (q_addr),
    .q_write_o        (q_write),
    .q_strb_o         (q_strb),
    .q_data_o         (q_data),
    .q_valid_o        (q_valid),
    .q_ready_i        (q_ready),
    .p_data_i         (p_data),
    .p_valid_i        (p_valid),
    .p_ready_o        (p_ready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req_set(input logic [31:0] add, input logic wen, input logic [3:0] be,
                         input logic [31:0] data, input logic [7:0] id);
    periph_req  = 1'b1;
    periph_add  = add;
    periph_wen  = wen;
    periph_be   = be;
    periph_data = data;
    periph_id   = id;
  endtask

  // Issue one read request that must be granted this cycle.
  task automatic grant_read(input logic [31:0] add, input logic [7:0] id, input string tag);
    req_set(add, 1'b1, 4'h0, 32'h0, id);
    #2;
    check(tag, periph_gnt, 1'b1);
    $display("req  id=%0d add=0x%0h gnt=%0b", id, add, periph_gnt);
    tick();
    periph_req = 1'b0;
  endtask

  // One p response and the two following idle cycles; r_valid must pulse
  // exactly once, vcyc cycles after the handshake, with the given id/data.
  task automatic do_rsp(input logic [31:0] data, input logic [7:0] exp_id);
    for (int c = 0; c < 3; c++) begin
      p_valid = (c == 0);
      p_data  = data;
      #2;
      check("rsp_valid", r_valid, (c == vcyc));
      if (c == vcyc) begin
        check("rsp_data", r_data, data);
        check("rsp_id", r_id, exp_id);
        $display("rsp  id=%0d data=0x%0h (expect id=%0d)", r_id, r_data, exp_id);
      end
      tick();
    end
    p_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef HWPE_CTRL_PERIPH2REQRSP_RSP_REG_EN
    vcyc = 1;
`else
    vcyc = 0;
`endif
    rst = 1'b1; periph_req = 1'b0; periph_add = '0; periph_wen = 1'b0;
    periph_be = '0; periph_data = '0; periph_id = '0;
    q_ready = 1'b0; p_data = '0; p_valid = 1'b0;
    tick();
    // Reset state, with req and p_valid pushed while in reset
    periph_req = 1'b1; p_valid = 1'b1;
    #2;
    check("rst_gnt", periph_gnt, 1'b0);
    check("rst_p_ready", p_ready, 1'b0);
    check("rst_r_valid", r_valid, 1'b0);
    check("rst_r_data", r_data, 32'h0);
    check("rst_r_id", r_id, 8'h0);
    check("rst_q_valid", q_valid, 1'b0);
    check("rst_q_addr", q_addr, 32'h0);
    check("rst_q_write", q_write, 1'b0);
    check("rst_q_strb", q_strb, 4'h0);
    check("rst_q_data", q_data, 32'h0);
    $display("reset state checked");
    tick();
    rst = 1'b0; periph_req = 1'b0; p_valid = 1'b0;
    tick();

    // Stray response at cnt==0 right after reset: no r_valid
    p_valid = 1'b1; p_data = 32'h5A5A5A5A;
    #2;
    check("p_ready", p_ready, 1'b1);
    check("stray0_valid", r_valid, 1'b0);
    tick();
    p_valid = 1'b0;
    #2;
    check("stray0_valid_n", r_valid, 1'b0);
    tick();

    // ---- Single read: strobe forced to all ones ----
    q_ready = 1'b0;
    req_set(32'h100, 1'b1, 4'h5, 32'h0, 8'd3);
    #2;
    check("rd_gnt", periph_gnt, 1'b1);
    tick();
    periph_req = 1'b0;
    q_ready = 1'b1;
    #2;
    check("rd_q_valid", q_valid, 1'b1);
    check("rd_q_write", q_write, 1'b0);
    check("rd_q_strb", q_strb, 4'hF);
    check("rd_q_addr", q_addr, 32'h100);
    $display("q    addr=0x%0h write=%0b strb=0x%0h", q_addr, q_write, q_strb);
    tick();
    q_ready = 1'b0;
    #2;
    check("rd_q_drained", q_valid, 1'b0);
    check("rd_no_rsp_yet", r_valid, 1'b0);
    tick();
    do_rsp(32'hDEADBEEF, 8'd3);

    // ---- Write ----
    q_ready = 1'b1;
    req_set(32'h104, 1'b0, 4'h3, 32'h12345678, 8'd7);
    #2;
    check("wr_gnt", periph_gnt, 1'b1);
    tick();
    periph_req = 1'b0;
    #2;
    check("wr_q_valid", q_valid, 1'b1);
    check("wr_q_write", q_write, 1'b1);
    check("wr_q_strb", q_strb, 4'h3);
    check("wr_q_data", q_data, 32'h12345678);
    $display("q    addr=0x%0h write=%0b strb=0x%0h data=0x%0h", q_addr, q_write, q_strb, q_data);
    tick();
    do_rsp(32'h0BADF00D, 8'd7);

    // ---- Request backpressure ----
    q_ready = 1'b0;
    req_set(32'h200, 1'b1, 4'h0, 32'h0, 8'd10);
    #2;
    check("bp_gnt_a", periph_gnt, 1'b1);
    tick();
    req_set(32'h204, 1'b0, 4'hF, 32'hAAAA5555, 8'd11);
    for (int i = 0; i < 5; i++) begin
      #2;
      check("bp_gnt_stall", periph_gnt, 1'b0);
      check("bp_q_valid", q_valid, 1'b1);
      check("bp_q_addr_stable", q_addr, 32'h200);
      $display("stall cycle %0d gnt=%0b q_addr=0x%0h", i, periph_gnt, q_addr);
      tick();
    end
    q_ready = 1'b1;
    #2;
    check("bp_gnt_b", periph_gnt, 1'b1);
    check("bp_q_addr_a", q_addr, 32'h200);
    tick();
    periph_req = 1'b0;
    #2;
    check("bp_q_valid_b", q_valid, 1'b1);
    check("bp_q_addr_b", q_addr, 32'h204);
    check("bp_q_write_b", q_write, 1'b1);
    check("bp_q_data_b", q_data, 32'hAAAA5555);
    tick();
    do_rsp(32'h11110010, 8'd10);
    do_rsp(32'h11110011, 8'd11);

    // ---- Outstanding limit and FIFO wrap ----
    q_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      grant_read(32'h300 + 32'(4 * i), 8'(i), "lim_gnt");
    end
    req_set(32'h314, 1'b1, 4'h0, 32'h0, 8'd5);
    for (int i = 0; i < 2; i++) begin
      #2;
      check("lim_gnt5_blocked", periph_gnt, 1'b0);
      tick();
    end
    // First response: the 5th grant must wait one more cycle
    for (int c = 0; c < 2; c++) begin
      p_valid = (c == 0);
      p_data  = 32'h50000001;
      #2;
      check("lim_gnt5", periph_gnt, (c == 1));
      check("lim_rsp1_valid", r_valid, (c == vcyc));
      if (c == vcyc) begin
        check("lim_rsp1_id", r_id, 8'd1);
        check("lim_rsp1_data", r_data, 32'h50000001);
      end
      $display("limit cycle %0d gnt=%0b r_valid=%0b r_id=%0d", c, periph_gnt, r_valid, r_id);
      tick();
    end
    periph_req = 1'b0;
    p_valid = 1'b0;
    for (int i = 2; i <= 5; i++) begin
      do_rsp(32'h50000000 + 32'(i), 8'(i));
    end

    // ---- Simultaneous grant and pop at cnt==2 ----
    grant_read(32'h400, 8'd20, "sim_gnt20");
    grant_read(32'h404, 8'd21, "sim_gnt21");
    for (int c = 0; c < 2; c++) begin
      if (c == 0) req_set(32'h408, 1'b1, 4'h0, 32'h0, 8'd22);
      else        periph_req = 1'b0;
      p_valid = (c == 0);
      p_data  = 32'h60000020;
      #2;
      check("sim_gnt22", periph_gnt, (c == 0));
      check("sim_rsp_valid", r_valid, (c == vcyc));
      if (c == vcyc) begin
        check("sim_rsp_id", r_id, 8'd20);
      end
      tick();
    end
    p_valid = 1'b0;
    // Count must still be 2: exactly two more grants fit
    grant_read(32'h40C, 8'd23, "sim_gnt23");
    grant_read(32'h410, 8'd24, "sim_gnt24");
    req_set(32'h414, 1'b1, 4'h0, 32'h0, 8'd25);
    #2;
    check("sim_gnt25_blocked", periph_gnt, 1'b0);
    tick();
    periph_req = 1'b0;
    for (int i = 21; i <= 24; i++) begin
      do_rsp(32'h60000000 + 32'(i), 8'(i));
    end

    // ---- Reset mid-flight ----
    grant_read(32'h700, 8'd30, "mid_gnt30");
    grant_read(32'h704, 8'd31, "mid_gnt31");
    grant_read(32'h708, 8'd32, "mid_gnt32");
    rst = 1'b1;
    req_set(32'h70C, 1'b1, 4'h0, 32'h0, 8'd33);
    p_valid = 1'b1; p_data = 32'h77777777;
    #2;
    check("mid_rst_gnt", periph_gnt, 1'b0);
    check("mid_rst_p_ready", p_ready, 1'b0);
    check("mid_rst_r_valid", r_valid, 1'b0);
    tick();
    #2;
    check("mid_rst_q_valid", q_valid, 1'b0);
    check("mid_rst_q_addr", q_addr, 32'h0);
    check("mid_rst_q_strb", q_strb, 4'h0);
    check("mid_rst_r_valid2", r_valid, 1'b0);
    check("mid_rst_r_data", r_data, 32'h0);
    check("mid_rst_r_id", r_id, 8'h0);
    check("mid_rst_gnt2", periph_gnt, 1'b0);
    $display("mid-flight reset applied");
    tick();
    rst = 1'b0; periph_req = 1'b0; p_valid = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      p_valid = 1'b1; p_data = 32'h88880000 + 32'(k);
      #2;
      check("late_rsp_valid", r_valid, 1'b0);
      tick();
      p_valid = 1'b0;
      #2;
      check("late_rsp_valid_n", r_valid, 1'b0);
      $display("late rsp %0d r_valid=%0b", k, r_valid);
      tick();
    end
    // Count back at 0 and pointers realigned: four grants, then blocked
    for (int i = 40; i <= 43; i++) begin
      grant_read(32'h800 + 32'(i), 8'(i), "post_gnt");
    end
    req_set(32'h8FF, 1'b1, 4'h0, 32'h0, 8'd44);
    #2;
    check("post_gnt44_blocked", periph_gnt, 1'b0);
    tick();
    periph_req = 1'b0;
    for (int i = 40; i <= 43; i++) begin
      do_rsp(32'h90000000 + 32'(i), 8'(i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
